// File: rtl/dmem_responder_if.sv
// Core-side data memory bus for dmem_responder: the core drives the address, store data and write enable.
// The responder drives back load data, the timer interrupt flag and the sticky access-error flag.
interface dmem_responder_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] ram_address;
   logic [WIDTH-1:0] ram_w_data;
   logic             read_write_ram_en;
   logic [WIDTH-1:0] ram_r_data;
   logic             timer_irq;
   logic             access_err;

   modport master (
      output ram_address, ram_w_data, read_write_ram_en,
      input  ram_r_data, timer_irq, access_err
   );

   modport slave (
      input  ram_address, ram_w_data, read_write_ram_en,
      output ram_r_data, timer_irq, access_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-cycle data memory for a pipelined core: word RAM with a zero-latency read path, plus optional
// MMIO cycle counter / timer compare block, built only when DMEM_MMIO_TIMER_EN is defined.
module dmem_responder #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256
) (
   input  logic             clock,
   input  logic             reset,
   dmem_responder_if.slave  bus
);
   localparam int ADDR_BITS = $clog2(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [ADDR_BITS-1:0] word_index;
   logic                 aligned;
   logic                 ram_hit;
   logic                 mmio_write_hit;
   logic                 ram_write;
   logic                 write_err;
   logic                 access_err;
   logic [WIDTH-1:0]     r_data;

   assign word_index = bus.ram_address[ADDR_BITS+1:2];
   assign aligned    = (bus.ram_address[1:0] == 2'b00);
   assign ram_hit    = (bus.ram_address[WIDTH-1:ADDR_BITS+2] == '0);
   assign ram_write  = bus.read_write_ram_en && aligned && ram_hit;

   // CYCLE is read-only, so only MTIMECMP and STATUS count as legal MMIO write targets.
   assign write_err  = bus.read_write_ram_en && !(aligned && (ram_hit || mmio_write_hit));

`ifdef DMEM_MMIO_TIMER_EN
   localparam logic [WIDTH-1:0] CYCLE_ADDR  = WIDTH'(32'h8000_0000);
   localparam logic [WIDTH-1:0] CMP_ADDR    = WIDTH'(32'h8000_0004);
   localparam logic [WIDTH-1:0] STATUS_ADDR = WIDTH'(32'h8000_0008);

   logic [31:0] cycle_count;
   logic [31:0] mtimecmp;
   logic        irq_pending;
   logic        cycle_hit;
   logic        cmp_hit;
   logic        status_hit;

   assign cycle_hit      = (bus.ram_address == CYCLE_ADDR);
   assign cmp_hit        = (bus.ram_address == CMP_ADDR);
   assign status_hit     = (bus.ram_address == STATUS_ADDR);
   assign mmio_write_hit = cmp_hit || status_hit;

   // Compare uses the registered MTIMECMP, so a new compare value takes effect one cycle after its write.
   // A match in the same cycle as a W1C wins, so the interrupt is never lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_count <= 32'h0000_0000;
         mtimecmp    <= 32'hFFFF_FFFF;
         irq_pending <= 1'b0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (bus.read_write_ram_en && cmp_hit)
            mtimecmp <= 32'(bus.ram_w_data);
         if (cycle_count == mtimecmp)
            irq_pending <= 1'b1;
         else if (bus.read_write_ram_en && status_hit && bus.ram_w_data[0])
            irq_pending <= 1'b0;
      end
   end

   assign bus.timer_irq = irq_pending;
`else
   assign mmio_write_hit = 1'b0;
   assign bus.timer_irq  = 1'b0;
`endif

   // RAM is deliberately not reset; a write that coincides with reset is simply dropped.
   always_ff @(posedge clock) begin
      if (!reset && ram_write)
         mem[word_index] <= bus.ram_w_data;
   end

   always_ff @(posedge clock) begin
      if (reset)
         access_err <= 1'b0;
      else if (write_err)
         access_err <= 1'b1;
   end

   always_comb begin
      r_data = '0;
      if (aligned) begin
         if (ram_hit)
            r_data = mem[word_index];
`ifdef DMEM_MMIO_TIMER_EN
         else if (cycle_hit)
            r_data = WIDTH'(cycle_count);
         else if (cmp_hit)
            r_data = WIDTH'(mtimecmp);
         else if (status_hit)
            r_data = WIDTH'({31'b0, irq_pending});
`endif
      end
   end

   assign bus.ram_r_data = r_data;
   assign bus.access_err = access_err;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 256, number of RAM words; SHALL be a power of two; ADDR_BITS = log2(DEPTH).
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ram_address  input  WIDTH  byte address from the core's EX/MEM register.
REQ-006 ram_w_data  input  WIDTH  store data.
REQ-007 read_write_ram_en  input  1  1 = write this cycle, 0 = read.
REQ-008 ram_r_data  output  WIDTH  load data; combinational in ram_address.
REQ-009 timer_irq  output  1  timer compare pending flag.
REQ-010 access_err  output  1  sticky misaligned or unmapped write flag.

Function
REQ-011 Address map: RAM 0x0 to 4*DEPTH-1, word index = ram_address[ADDR_BITS+1:2]; MMIO 0x8000_0000 CYCLE (RO), 0x8000_0004 MTIMECMP (RW), 0x8000_0008 STATUS (bit0 = irq pending, W1C); all other addresses are unmapped.
REQ-012 Read path is zero-latency: ram_r_data reflects the addressed word/register in the same cycle, so the core's MEM/WB register samples it at the next edge.
REQ-013 Unmapped or misaligned (ram_address[1:0] != 0) reads return 0 and do not set access_err.
REQ-014 Writes commit on the rising edge when read_write_ram_en=1; the read in the same cycle returns the pre-write value.
REQ-015 A write with ram_address[1:0] != 0, or to an unmapped address or CYCLE, is discarded and sets access_err on that edge.
REQ-016 CYCLE increments by 1 every clock not in reset and wraps 0xFFFF_FFFF -> 0x0000_0000.
REQ-017 A write to MTIMECMP updates it at that edge; the new value is used for comparison from the next cycle.
REQ-018 timer_irq sets on the edge after the cycle in which CYCLE == MTIMECMP, and stays set until a STATUS write with bit0=1.
REQ-019 A STATUS write with bit0=0 has no effect; a simultaneous compare match and W1C leaves timer_irq set (set wins).
REQ-020 STATUS reads return {31'b0, timer_irq}.
REQ-021 Back-to-back writes on consecutive cycles each commit; no stall or handshake is required by the core.

Reset
REQ-022 On reset: CYCLE=0, MTIMECMP=0xFFFF_FFFF, timer_irq=0, access_err=0.
REQ-023 RAM contents are not altered by reset; a write asserted during reset is discarded.
REQ-024 Reset asserted mid-operation takes effect at the next edge regardless of read_write_ram_en.

Configuration
REQ-025 Macro DMEM_MMIO_TIMER_EN: when defined, CYCLE/MTIMECMP/STATUS and timer_irq behave per REQ-011 and REQ-016..REQ-020.
REQ-026 Without DMEM_MMIO_TIMER_EN, the 0x8000_000x addresses are unmapped (reads return 0, writes set access_err), timer_irq is constant 0, and no counter logic is built.

Verification
REQ-027 Write 0xDEADBEEF to 0x10, then read 0x10 -> ram_r_data=0xDEADBEEF the cycle after the write; same-cycle read during the write -> old value.
REQ-028 Write 0x1234 to 0x13 -> RAM word 4 unchanged, access_err=1 from the next edge until reset.
REQ-029 (EN) Release reset, read 0x8000_0000 on the 5th clock after release -> 4; write MTIMECMP=20 -> timer_irq rises on the edge after CYCLE==20.
REQ-030 (EN) With timer_irq=1, write STATUS=0x1 -> timer_irq=0 next cycle; repeat the W1C in the match cycle -> timer_irq stays 1.
REQ-031 (EN) Force CYCLE near wrap (MTIMECMP=0, run 2^32 cycles, or force in sim) -> 0xFFFF_FFFF then 0x0, with irq set on the edge after CYCLE==0.
REQ-032 Without macro: read 0x8000_0000 -> 0; write 0x8000_0004 -> access_err=1; timer_irq stays 0 throughout.
